// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: sizes, FSM states and the
// rotating-priority winner search used by rr_arbiter8.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Search upward from ptr (wrapping) for the first eligible requester.
  // Walking the offsets from highest to lowest lets the smallest offset
  // overwrite the result last, so no early exit is needed.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input logic [NUM_REQ-1:0] mask);
    pick_t              res;
    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   cand;
    res      = '0;
    eligible = req & mask;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (eligible[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

  // Binary index to one-hot vector.
  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/encoder8_3.sv
// 8-to-3 priority encoder: Eo is the index of the highest set bit of Din,
// or 0 when nothing is set or the encoder is disabled.
module encoder8_3 (
  input  logic [7:0] Din,
  input  logic       En,
  output logic [2:0] Eo
);

  // Scan low to high so the highest set bit wins.
  always_comb begin
    Eo = 3'd0;
    if (En) begin
      for (int i = 0; i < 8; i++) begin
        if (Din[i]) Eo = 3'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant,
// hold-until-release handshake and an optional hold timeout that forces
// a handover to a waiting requester.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               En,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               preempt
);

  localparam bit TimeoutEn = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HoldLimit =
    (MAX_HOLD == 0) ? HOLD_W'(0) : HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               preempt_q, preempt_d;

  pick_t              pickAll;
  pick_t              pickOthers;
  logic               holdAtLimit;

  // Candidate winners: any requester, or any requester other than the owner
  // (used only when a timeout forces the grant away from cur).
  always_comb begin
    pickAll     = rr_pick(req, ptr_q, {NUM_REQ{1'b1}});
    pickOthers  = rr_pick(req, ptr_q, ~idx2onehot(cur_q));
    holdAtLimit = TimeoutEn && (hold_q == HoldLimit);
  end

  // State register: everything drops at once on async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      cur_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cur_q     <= cur_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  // Next state: issue, hand over, retain or release the grant.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cur_d     = cur_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (En && pickAll.found) begin
          state_d = GRANT;
          gnt_d   = idx2onehot(pickAll.idx);
          cur_d   = pickAll.idx;
          ptr_d   = pickAll.idx + IDX_W'(1);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[cur_q]) begin
          if (En && pickAll.found) begin
            gnt_d  = idx2onehot(pickAll.idx);
            cur_d  = pickAll.idx;
            ptr_d  = pickAll.idx + IDX_W'(1);
            hold_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (En && holdAtLimit) begin
          hold_d = '0;
          if (pickOthers.found) begin
            gnt_d     = idx2onehot(pickOthers.idx);
            cur_d     = pickOthers.idx;
            ptr_d     = pickOthers.idx + IDX_W'(1);
            preempt_d = 1'b1;
          end
        end else if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs come straight from registers; the index is derived from gnt.
  always_comb begin
    gnt       = gnt_q;
    gnt_valid = |gnt_q;
    preempt   = preempt_q;
  end

  encoder8_3 uEncoder (
    .Din (gnt_q),
    .En  (1'b1),
    .Eo  (gnt_idx)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8 (MAX_HOLD=4): a table of directed vectors, a few
// hand-written corner sequences and a randomized run against a reference model.
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       En  = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int passes = 0;

  int mOwner;
  int mPtr;
  int mHold;
  bit mPre;

  typedef struct {
    bit         doReset;
    logic       en;
    logic [7:0] req;
    logic [7:0] expGnt;
    logic       expPre;
    string      name;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .En        (En),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic int firstFrom(logic [7:0] r, int from);
    for (int k = 0; k < 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  function automatic int idxOf(logic [7:0] g);
    for (int k = 0; k < 8; k++) if (g[k]) return k;
    return 0;
  endfunction

  task automatic modelReset();
    mOwner = -1;
    mPtr   = 0;
    mHold  = 0;
    mPre   = 0;
  endtask

  task automatic modelGrant(int i);
    mOwner = i;
    mPtr   = (i + 1) % 8;
    mHold  = 0;
  endtask

  // One clock edge of the arbiter's rules, expressed with plain integers.
  task automatic modelStep(logic [7:0] r, logic e);
    logic [7:0] others;
    mPre = 0;
    if (mOwner < 0) begin
      if (e && r != 0) modelGrant(firstFrom(r, mPtr));
    end else if (!r[mOwner]) begin
      if (e && r != 0) modelGrant(firstFrom(r, mPtr));
      else begin
        mOwner = -1;
        mHold  = 0;
      end
    end else if (MAXH != 0 && e && mHold == MAXH - 1) begin
      others = r;
      others[mOwner] = 1'b0;
      if (others != 0) begin
        modelGrant(firstFrom(others, mPtr));
        mPre = 1;
      end else mHold = 0;
    end else if (mHold < 255) mHold++;
  endtask

  function automatic logic [7:0] modelGnt();
    logic [7:0] g;
    g = 8'h00;
    if (mOwner >= 0) g[mOwner] = 1'b1;
    return g;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic checkOutput(string name, logic [7:0] expGnt, logic expPre);
    check({name, ".gnt"}, int'(gnt), int'(expGnt));
    check({name, ".gnt_idx"}, int'(gnt_idx), idxOf(expGnt));
    check({name, ".gnt_valid"}, int'(gnt_valid), int'(expGnt != 0));
    check({name, ".preempt"}, int'(preempt), int'(expPre));
  endtask

  task automatic applyStimulus(logic [7:0] r, logic e);
    req = r;
    En  = e;
    @(posedge clk);
    modelStep(r, e);
    #1;
  endtask

  task automatic resetDut();
    req = 8'h00;
    En  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic addVec(bit dr, logic e, logic [7:0] r, logic [7:0] g, logic p, string n);
    vecs.push_back('{dr, e, r, g, p, n});
  endtask

  initial begin
    logic [7:0] rq;
    logic       en;

    // Single request after reset, then release.
    addVec(1, 1, 8'h04, 8'h04, 0, "single");
    addVec(0, 1, 8'h00, 8'h00, 0, "release");
    // Fairness with no dead cycle on handover.
    addVec(1, 1, 8'h81, 8'h01, 0, "rr0");
    addVec(0, 1, 8'h80, 8'h80, 0, "rr7");
    addVec(0, 1, 8'h01, 8'h01, 0, "rr0b");
    addVec(0, 1, 8'h80, 8'h80, 0, "rr7b");
    // Timeout handover in both directions.
    addVec(1, 1, 8'h03, 8'h01, 0, "to_h1");
    addVec(0, 1, 8'h03, 8'h01, 0, "to_h2");
    addVec(0, 1, 8'h03, 8'h01, 0, "to_h3");
    addVec(0, 1, 8'h03, 8'h01, 0, "to_h4");
    addVec(0, 1, 8'h03, 8'h02, 1, "to_pre1");
    addVec(0, 1, 8'h03, 8'h02, 0, "to_h5");
    addVec(0, 1, 8'h03, 8'h02, 0, "to_h6");
    addVec(0, 1, 8'h03, 8'h02, 0, "to_h7");
    addVec(0, 1, 8'h03, 8'h01, 1, "to_pre2");
    addVec(0, 1, 8'h03, 8'h01, 0, "to_after");
    // Release coinciding with timeout is a plain release.
    addVec(1, 1, 8'h03, 8'h01, 0, "rt_h1");
    addVec(0, 1, 8'h03, 8'h01, 0, "rt_h2");
    addVec(0, 1, 8'h03, 8'h01, 0, "rt_h3");
    addVec(0, 1, 8'h03, 8'h01, 0, "rt_h4");
    addVec(0, 1, 8'h02, 8'h02, 0, "rt_rel");
    // En gating: idle stays idle, then grant from ptr 0.
    addVec(1, 0, 8'hFF, 8'h00, 0, "en_off1");
    addVec(0, 0, 8'hFF, 8'h00, 0, "en_off2");
    addVec(0, 1, 8'hFF, 8'h01, 0, "en_on");
    // En low in GRANT: hold past the limit, then release to idle.
    addVec(1, 1, 8'h03, 8'h01, 0, "eg_g");
    for (int i = 0; i < 6; i++) addVec(0, 0, 8'h03, 8'h01, 0, "eg_hold");
    addVec(0, 0, 8'h02, 8'h00, 0, "eg_rel");

    rst = 1'b1;
    #12;
    rst = 1'b0;
    modelReset();
    checkOutput("reset", 8'h00, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].doReset) resetDut();
      applyStimulus(vecs[i].req, vecs[i].en);
      checkOutput(vecs[i].name, vecs[i].expGnt, vecs[i].expPre);
    end

    // Timeout with no contender: grant retained, never preempted.
    resetDut();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h10, 1'b1);
      checkOutput("solo", 8'h10, 1'b0);
    end

    // Async reset between edges drops the grant with no clock.
    resetDut();
    applyStimulus(8'h20, 1'b1);
    checkOutput("ar_grant", 8'h20, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("ar_async", 8'h00, 1'b0);
    modelReset();
    #1;
    rst = 1'b0;
    applyStimulus(8'h21, 1'b1);
    checkOutput("ar_after", 8'h01, 1'b0);

    // Randomized run against the reference model.
    resetDut();
    rq = 8'h00;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      en = ($urandom_range(0, 9) != 0);
      applyStimulus(rq, en);
      checkOutput("rand", modelGnt(), mPre);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters and reports the winner in encoded form.
- The index output uses the same encoding as encoder8_3.
- Sits in front of any shared single-port resource in the design.
- Registered one-hot grant, hold-until-release handshake, optional hold timeout that forces a handover.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold a grant while others wait; 0 disables the timeout (range 0..255).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- En  input  1  arbitration enable; when 0, no new grant is issued
- req  input  8  request lines, bit i = requester i, level-sensitive
- gnt  output  8  one-hot registered grant
- gnt_idx  output  3  binary index of the granted requester; valid only when gnt_valid=1
- gnt_valid  output  1  1 when any gnt bit is set
- preempt  output  1  one-cycle pulse on a timeout-forced handover

Behaviour:
- Reset (async, rst=1):
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
  - Round-robin pointer ptr=0, hold counter=0, state IDLE.
  - Reset asserted mid-grant drops the grant immediately, with no clock required.
- States: IDLE (no grant), GRANT (gnt holds one requester, cur).
- Winner selection (combinational):
  - First requester with req=1 found when searching upward from ptr, wrapping modulo 8 (ptr, ptr+1, ..., ptr+7).
  - The search mask excludes cur when a handover is being forced.
- IDLE:
  - If En=1 and req!=0 at a clock edge: gnt=onehot(winner), state GRANT, hold counter=0.
  - Latency is 1 clock from request sampled to grant visible.
  - Otherwise remain in IDLE.
- GRANT, normal release (req[cur]=0 sampled at an edge):
  - If En=1 and another req is set: grant goes to the new winner at that same edge, with no dead cycle.
  - Otherwise gnt=0 and state returns to IDLE.
- GRANT, hold:
  - While req[cur]=1, gnt stays unchanged and the hold counter increments (saturating at 255).
- GRANT, timeout:
  - Trigger: MAX_HOLD!=0, counter==MAX_HOLD-1, req[cur]=1, En=1, and another req is set.
  - At that edge the grant moves to the winner among the others, preempt=1 for exactly one cycle, counter=0.
  - If no other requester is set, the grant is retained and the counter restarts at 0 with no preempt.
- Pointer update:
  - On every new grant to index i, ptr=(i+1) mod 8.
  - Retaining a grant does not move ptr.
- En=0 while in GRANT: the current grant is held until release; then the block goes to IDLE with no re-arbitration. The timeout is suppressed.
- Output invariants:
  - gnt is always 0 or exactly one-hot.
  - gnt_idx=encode(gnt).
  - gnt_valid=|gnt.
- Simultaneous events:
  - Release and timeout in the same cycle: treat as a normal release, preempt=0.
  - Requests arriving in the same cycle are resolved by ptr order only.

Decomposition:
- Shared package arb_pkg holds:
  - NUM_REQ=8, IDX_W=3, HOLD_W=8.
  - State enum {IDLE, GRANT}.
  - Function rr_pick(req, ptr, mask) returning a winner index and a found flag.
- Sub-module: instantiate the existing encoder8_3 with Din=gnt, En=1'b1 and Eo=gnt_idx. This is valid because gnt is guaranteed one-hot or zero.
- All state registers live in rr_arbiter8.

Test Plan:
- Reset then single request: req=8'h04 -> one clock later gnt=8'h04, gnt_idx=2, gnt_valid=1. With ptr=0 the search goes 0,1,2, so requester 2 wins; ptr becomes 3 on the grant.
- Round-robin fairness: req=8'h81 held, each owner drops its request for one cycle on release:
  - Grant order is 0 then 7 then 0, never granting the same index twice while the other waits.
  - Each handover happens with no gnt=0 cycle.
- Timeout: MAX_HOLD=4, req=8'h03 held continuously:
  - gnt=8'h01 for 4 cycles, then gnt=8'h02 with preempt=1 for one cycle.
  - After another 4 cycles, gnt=8'h01 with preempt=1.
- Timeout with no contender: MAX_HOLD=4, req=8'h10 held for 20 cycles -> gnt=8'h10 throughout, preempt never 1.
- En gating: En=0 with req=8'hFF -> gnt stays 0. Raise En -> next edge gnt=onehot(ptr).
- Async reset mid-grant: gnt=8'h20, assert rst between edges -> gnt=0 and gnt_valid=0 immediately. After release and req=8'h21, first grant is gnt=8'h01 (ptr reset to 0).
